// File: rtl/uart_result_tx.sv
// uart_result_tx: 16x-oversampled UART transmitter with a one-entry holding register; even parity bit when UART_TX_PARITY_EN is defined
module uart_result_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clock,
    input  logic            i_reset_n,
    input  logic            i_tick,
    input  logic            i_start,
    input  logic [DBIT-1:0] i_data,
    output logic            o_tx,
    output logic            o_busy,
    output logic            o_done_tick,
    output logic            o_pending,
    output logic            o_overrun
);
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t          state_q;
    logic [3:0]      tick_q;
    logic [BW-1:0]   bit_q;
    logic [DBIT-1:0] shreg_q;
    logic [DBIT-1:0] hold_q;
    logic            pending_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;
    logic            overrun_q;
`ifdef UART_TX_PARITY_EN
    logic            par_q;
`endif
    logic [DBIT-1:0] load_data;
    logic            bit_end;
    logic            stop_end;

    // Next frame comes from the holding register when it is full, otherwise from the live request
    always_comb begin
        load_data = pending_q ? hold_q : i_data;
        bit_end   = i_tick && tick_q == 4'd15;
        stop_end  = i_tick && tick_q == 4'(SB_TICK - 1);
    end

    // Frame sequencer, holding register and registered line/status outputs
    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            if (i_start && (state_q != IDLE || pending_q)) begin
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    hold_q    <= i_data;
                    pending_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (pending_q || i_start) begin
                        shreg_q   <= load_data;
`ifdef UART_TX_PARITY_EN
                        par_q     <= ^load_data;
`endif
                        pending_q <= 1'b0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        tick_q    <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else if (i_tick) begin
                        tick_q <= tick_q + 4'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        shreg_q <= shreg_q >> 1;
                        if (bit_q == BW'(DBIT - 1)) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BW'(1);
                            tx_q  <= shreg_q[1];
                        end
                    end else if (i_tick) begin
                        tick_q <= tick_q + 4'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else if (i_tick) begin
                        tick_q <= tick_q + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (stop_end) begin
                        tick_q <= '0;
                        done_q <= 1'b1;
                        if (pending_q) begin
                            shreg_q   <= hold_q;
`ifdef UART_TX_PARITY_EN
                            par_q     <= ^hold_q;
`endif
                            pending_q <= 1'b0;
                            tx_q      <= 1'b0;
                            state_q   <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (i_tick) begin
                        tick_q <= tick_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx        = tx_q;
    assign o_busy      = busy_q;
    assign o_done_tick = done_q;
    assign o_pending   = pending_q;
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: table-driven frames plus hand-written sequences, decoded by a tick-counting receiver against a queue of expected bytes
module tb_uart_result_tx;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = 16 * (9 + PB) + 16;
    localparam int LAST  = 9 + PB;

    typedef struct packed {logic [7:0] d; logic p;} exp_t;
    typedef struct {logic [7:0] d; int gap; logic p;} vec_t;

    logic       clock = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_tx, o_busy, o_done_tick, o_pending, o_overrun;

    int   checks = 0;
    int   failures = 0;
    int   gap = 1;
    int   done_cnt = 0;
    int   ovr_cnt = 0;
    int   tcnt = 0;
    logic rx_act = 1'b0;
    logic [7:0] rx_byte;
    logic rx_par;
    logic done_tx, done_busy, done_pend;
    exp_t exp_q[$];
    vec_t vecs[6];

    uart_result_tx dut (
        .clock(clock), .i_reset_n(i_reset_n), .i_tick(i_tick), .i_start(i_start),
        .i_data(i_data), .o_tx(o_tx), .o_busy(o_busy), .o_done_tick(o_done_tick),
        .o_pending(o_pending), .o_overrun(o_overrun)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    initial begin
        int tc;
        tc = 0;
        forever begin
            @(posedge clock);
            #1;
            if (gap == 0) begin
                i_tick = 1'b0;
            end else begin
                tc = (tc + 1) % gap;
                i_tick = (tc == 0);
            end
        end
    end

    initial begin
        int k;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!i_reset_n) begin
                rx_act = 1'b0;
            end else begin
                if (o_done_tick) begin
                    done_cnt++;
                    done_tx = o_tx;
                    done_busy = o_busy;
                    done_pend = o_pending;
                    chk("done_in_frame", 32'(rx_act), 1);
                    chk("done_ticks", tcnt, FRAME);
                    rx_act = 1'b0;
                end
                if (o_overrun) ovr_cnt++;
                if (!rx_act && o_tx === 1'b0) begin
                    rx_act = 1'b1;
                    tcnt = 0;
                    rx_byte = 8'h00;
                    rx_par = 1'b0;
                end
                if (rx_act && i_tick) begin
                    tcnt++;
                    if (tcnt % 16 == 8) begin
                        k = tcnt / 16;
                        if (k == 0) chk("start_bit", 32'(o_tx), 0);
                        else if (k <= 8) rx_byte[k-1] = o_tx;
                        else if (k < LAST) rx_par = o_tx;
                        else if (k == LAST) begin
                            chk("stop_bit", 32'(o_tx), 1);
                            if (exp_q.size() == 0) begin
                                chk("unexpected_frame", 32'(rx_byte), 32'hFFFF_FFFF);
                            end else begin
                                e = exp_q.pop_front();
                                chk("rx_byte", 32'(rx_byte), 32'(e.d));
`ifdef UART_TX_PARITY_EN
                                chk("rx_parity", 32'(rx_par), 32'(e.p));
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(posedge clock);
        #1;
        i_data = d;
        i_start = 1'b1;
        @(posedge clock);
        #1;
        i_start = 1'b0;
        i_data = 8'($urandom);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("done_wait", 32'(done_cnt >= target), 1);
    endtask

    initial begin
        int base, ovr0, n;
        logic ok;
        vecs[0] = '{8'hA5, 1, 1'b0};
        vecs[1] = '{8'h07, 1, 1'b1};
        vecs[2] = '{8'h00, 1, 1'b0};
        vecs[3] = '{8'hFF, 2, 1'b0};
        vecs[4] = '{8'h80, 3, 1'b1};
        vecs[5] = '{8'h5A, 1, 1'b0};

        repeat (3) @(posedge clock);
        #1;
        i_reset_n = 1'b1;
        @(negedge clock);
        chk("rst_tx", 32'(o_tx), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done_tick), 0);
        chk("rst_pending", 32'(o_pending), 0);
        chk("rst_overrun", 32'(o_overrun), 0);

        for (int i = 0; i < 6; i++) begin
            gap = vecs[i].gap;
            exp_q.push_back('{vecs[i].d, vecs[i].p});
            base = done_cnt;
            send(vecs[i].d);
            @(negedge clock);
            chk("vec_busy_start", 32'(o_busy), 1);
            chk("vec_tx_start", 32'(o_tx), 0);
            wait_dones(base + 1, 200 * gap + 50);
            @(negedge clock);
            chk("vec_idle_busy", 32'(o_busy), 0);
            chk("vec_idle_tx", 32'(o_tx), 1);
        end

        gap = 1;
        base = done_cnt;
        exp_q.push_back('{8'h11, 1'b0});
        exp_q.push_back('{8'h22, 1'b0});
        send(8'h11);
        repeat (40) @(posedge clock);
        send(8'h22);
        @(negedge clock);
        chk("b2b_pending", 32'(o_pending), 1);
        wait_dones(base + 1, 400);
        chk("b2b_no_idle_tx", 32'(done_tx), 0);
        chk("b2b_busy_kept", 32'(done_busy), 1);
        chk("b2b_pending_clr", 32'(done_pend), 0);
        wait_dones(base + 2, 400);
        chk("b2b_end_tx", 32'(done_tx), 1);
        chk("b2b_end_busy", 32'(done_busy), 0);

        ovr0 = ovr_cnt;
        base = done_cnt;
        exp_q.push_back('{8'h01, 1'b1});
        exp_q.push_back('{8'h02, 1'b1});
        send(8'h01);
        repeat (20) @(posedge clock);
        send(8'h02);
        repeat (20) @(posedge clock);
        send(8'h03);
        @(negedge clock);
        chk("ovr_pulse", 32'(o_overrun), 1);
        chk("ovr_pending", 32'(o_pending), 1);
        wait_dones(base + 2, 500);
        chk("ovr_count", ovr_cnt - ovr0, 1);

        base = done_cnt;
        send(8'h3C);
        repeat (20) @(posedge clock);
        send(8'h77);
        n = 0;
        while (tcnt < 70 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("rst_reach_bit3", 32'(tcnt >= 70), 1);
        #1;
        i_reset_n = 1'b0;
        i_start = 1'b1;
        i_data = 8'hEE;
        @(posedge clock);
        #1;
        i_reset_n = 1'b1;
        i_start = 1'b0;
        @(negedge clock);
        chk("mid_rst_tx", 32'(o_tx), 1);
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_pending", 32'(o_pending), 0);
        repeat (400) @(posedge clock);
        chk("mid_rst_no_done", done_cnt, base);
        chk("mid_rst_still_idle", 32'(o_busy), 0);
        exp_q.push_back('{8'h5A, 1'b0});
        send(8'h5A);
        wait_dones(base + 1, 400);

        gap = 0;
        base = done_cnt;
        exp_q.push_back('{8'hA5, 1'b0});
        send(8'hA5);
        ok = 1'b1;
        repeat (60) begin
            @(negedge clock);
            if (o_tx !== 1'b0 || o_busy !== 1'b1) ok = 1'b0;
        end
        chk("no_tick_hold_start", 32'(ok), 1);
        gap = 1;
        wait_dones(base + 1, 400);

        repeat (5) @(posedge clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: oversample ticks in the stop bit.
REQ-003 SHALL have port clock  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port i_tick  input  1: 16x-oversample baud strobe from the baud rate generator, one cycle wide.
REQ-006 SHALL have port i_start  input  1: one-cycle request to transmit i_data.
REQ-007 SHALL have port i_data  input  DBIT: byte to send, typically the ALU result.
REQ-008 SHALL have port o_tx  output  1: registered serial line, idle high.
REQ-009 SHALL have port o_busy  output  1: high while a frame is in flight.
REQ-010 SHALL have port o_done_tick  output  1: one-cycle pulse at the end of each frame.
REQ-011 SHALL have port o_pending  output  1: high while the one-entry holding register is full.
REQ-012 SHALL have port o_overrun  output  1: one-cycle pulse when a request is dropped.

Function
REQ-013 SHALL implement the FSM states IDLE, START, DATA, (PARITY), STOP.
REQ-014 SHALL, in IDLE on i_start, latch i_data into the shift register and enter START; o_busy and o_tx=0 are asserted on the next cycle.
REQ-015 SHALL advance the 4-bit tick counter only on cycles with i_tick=1; a state bit lasts 16 ticks (STOP: SB_TICK ticks).
REQ-016 SHALL hold o_tx=0 in START, then enter DATA.
REQ-017 SHALL send data LSB first in DATA, shifting once per 16 ticks, with a bit counter 0..DBIT-1, then enter PARITY or STOP.
REQ-018 SHALL hold o_tx=1 in STOP; at the end of STOP it pulses o_done_tick for one cycle.
REQ-019 SHALL, at the end of STOP with the holding register empty, go to IDLE with o_busy=0.
REQ-020 SHALL, at the end of STOP with the holding register full, load the held byte, clear o_pending, and go directly to START with no idle cycle; o_busy stays 1.
REQ-021 SHALL, on i_start while busy with the holding register empty, store i_data there and set o_pending.
REQ-022 SHALL, on i_start while the holding register is full, drop the request, leave the held byte unchanged, and pulse o_overrun.
REQ-023 SHALL, on i_start in the same cycle that STOP ends, treat the request per REQ-021/022 against the holding-register state before that cycle.
REQ-024 SHALL ignore i_data except in cycles with i_start=1.

Reset
REQ-025 SHALL, on a clock edge with i_reset_n=0, force state=IDLE, o_tx=1, o_busy=0, o_done_tick=0, o_pending=0, o_overrun=0, and clear the counters, shift register and holding register.
REQ-026 SHALL abort any frame when reset occurs mid-frame; o_tx is 1 from the cycle after reset and no o_done_tick is generated.
REQ-027 SHALL ignore i_start while i_reset_n=0.

Configuration
REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, insert state PARITY between DATA and STOP; it holds o_tx = even parity (XOR of the DBIT data bits) for 16 ticks.
REQ-029 SHALL, without UART_TX_PARITY_EN, go directly from DATA to STOP with no parity hardware; the frame is 8N1 at default parameters.

Verification
REQ-030 SHALL cover: i_start with i_data=0xA5, no parity -> o_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; o_done_tick exactly once, 160 ticks after START begins.
REQ-031 SHALL cover: UART_TX_PARITY_EN defined, 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame length 176 ticks.
REQ-032 SHALL cover: i_start 0x11, then i_start 0x22 mid-frame -> o_pending=1; the second frame's start bit follows the first stop bit with no idle cycle; two o_done_tick pulses.
REQ-033 SHALL cover: three i_start pulses (0x01, 0x02, 0x03) within one frame -> o_overrun pulses once on the third; only 0x01 and 0x02 are transmitted.
REQ-034 SHALL cover: i_reset_n=0 during DATA bit 3 -> o_tx=1, o_busy=0, o_pending=0 the next cycle; no o_done_tick; a following i_start 0x5A transmits correctly.
REQ-035 SHALL cover: i_start held with i_tick never asserted -> o_tx stays 0 in START indefinitely; the counter does not advance.
